multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have inputs: Op in 6, instruction opcode from IR; MemReady in 1, memory access completes this cycle.
REQ-003 SHALL have outputs: IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, Branch, each out 1; ALUSrcB, ALUOp, PCSource, each out 2.
REQ-004 SHALL have outputs: State out 4, current state; IllegalOp out 1, sticky unsupported-opcode flag; InstrCount out 16, retired-instruction count.
REQ-005 ALUOp SHALL feed the downstream ALU-select decoder: 00 add, 01 subtract, 10 R-type funct decode; 11 never driven.

Function
REQ-006 SHALL be a Moore FSM with a registered 4-bit state: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-007 Unencoded states 12-15 SHALL go to FETCH on the next edge and drive all-zero outputs.
REQ-008 Any output not listed for a state SHALL be 0.
REQ-009 FETCH: MemRead=1, ALUSrcB=01, IRWrite=MemReady, PCWrite=MemReady; hold while MemReady=0; go to DECODE when MemReady=1.
REQ-010 DECODE: ALUSrcB=11.
REQ-011 DECODE next state by Op:
- 100011 (LW) or 101011 (SW) -> MEMADR
- 000000 -> EXECUTE
- 000100 (BEQ) -> BRANCH
- 001000 (ADDI) -> ADDIEXEC
- 000010 (J) -> JUMP
- any other value -> FETCH, and IllegalOp set to 1
REQ-012 MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10. MEMADR goes to MEMRD if Op=100011, else MEMWR. ADDIEXEC goes to ADDIWB.
REQ-013 MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then go to MEMWB.
REQ-014 MEMWR: MemWrite=1, IorD=1; hold until MemReady=1, then go to FETCH.
REQ-015 MEMWB: MemtoReg=1, RegWrite=1. ALUWB: RegDst=1, RegWrite=1. ADDIWB: RegWrite=1. Each goes to FETCH.
REQ-016 EXECUTE: ALUSrcA=1, ALUOp=10; goes to ALUWB.
REQ-017 BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, Branch=1; goes to FETCH.
REQ-018 JUMP: PCSource=10, PCWrite=1; goes to FETCH.
REQ-019 InstrCount SHALL increment by 1 on each edge where the FSM leaves MEMWB, ALUWB, ADDIWB, BRANCH or JUMP, or leaves MEMWR with MemReady=1.
REQ-020 InstrCount SHALL wrap from 0xFFFF to 0x0000; illegal opcodes SHALL NOT count.
REQ-021 IllegalOp SHALL stay 1 until reset.
REQ-022 With MemReady held at 1, total cycles per instruction SHALL be: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.

Reset
REQ-023 When reset=1 at a clock edge: State SHALL become FETCH, InstrCount 0, IllegalOp 0, regardless of current state or pending memory access.
REQ-024 While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and Branch SHALL be forced 0; all other outputs SHALL take their FETCH values.
REQ-025 Reset SHALL take priority over every transition and counter update in the same cycle.

Verification
REQ-026 Reset, MemReady=1, Op=100011 -> State 0,1,2,3,4,0; RegWrite=1 only in state 4; InstrCount=1 after 5 cycles.
REQ-027 Op=101011, MemReady=0 for 3 cycles in MEMWR -> State held at 5 with MemWrite=1; exits to 0 on the first MemReady=1; InstrCount+1.
REQ-028 Op=000000 -> ALUOp=10 in state 6; then state 7 with RegDst=1 and RegWrite=1. Op=000100 -> state 8 with ALUOp=01, Branch=1, PCSource=01.
REQ-029 Op=111111 in DECODE -> next State 0, IllegalOp=1 and stays 1 across later instructions; InstrCount unchanged.
REQ-030 Reset asserted in state 3 (MEMRD) -> next State 0, counters cleared; no RegWrite pulse.
REQ-031 Preload InstrCount to 0xFFFF via 65535 J instructions, then one more J -> InstrCount=0x0000.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bus between the multicycle datapath and its controller: opcode/memory handshake in,
// datapath control strobes and status out.
interface multicycle_control_if;
  logic [5:0]  Op;
  logic        MemReady;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        RegWrite;
  logic        ALUSrcA;
  logic        PCWrite;
  logic        Branch;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [1:0]  PCSource;
  logic [3:0]  State;
  logic        IllegalOp;
  logic [15:0] InstrCount;

  modport slave (
    input  Op, MemReady,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           PCWrite, Branch, ALUSrcB, ALUOp, PCSource, State, IllegalOp, InstrCount
  );

  modport master (
    output Op, MemReady,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           PCWrite, Branch, ALUSrcB, ALUOp, PCSource, State, IllegalOp, InstrCount
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with retired-instruction counter and sticky
// illegal-opcode flag.
//
// state    | meaning
// FETCH    | read instruction, PC+4 when memory ready
// DECODE   | register read, branch target compute
// MEMADR   | effective address for LW/SW
// MEMRD    | data read, wait for memory
// MEMWB    | load writeback
// MEMWR    | data write, wait for memory
// EXECUTE  | R-type ALU operation
// ALUWB    | R-type writeback
// BRANCH   | BEQ compare and conditional PC update
// ADDIEXEC | immediate add
// ADDIWB   | ADDI writeback
// JUMP     | unconditional PC update
module multicycle_control (
  input logic clk,
  input logic reset,
  multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0]  state_q;
  logic [3:0]  state_d;
  logic [15:0] instr_count;
  logic        illegal_q;
  logic        retire;
  logic        bad_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      instr_count <= 16'd0;
      illegal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + 16'd1;
      if (bad_op) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d       = FETCH;
    retire        = 1'b0;
    bad_op        = 1'b0;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.PCSource  = 2'b00;
    case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
        state_d     = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (bus.Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = bus.MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        retire       = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        state_d      = bus.MemReady ? FETCH : MEMWR;
        retire       = bus.MemReady;
      end
      EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        retire       = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = 2'b01;
        bus.PCSource = 2'b01;
        bus.Branch   = 1'b1;
        retire       = 1'b1;
      end
      ADDIEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        bus.RegWrite = 1'b1;
        retire       = 1'b1;
      end
      JUMP: begin
        bus.PCSource = 2'b10;
        bus.PCWrite  = 1'b1;
        retire       = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // While in reset, present a fetch with every state-changing strobe held off.
    if (reset) begin
      bus.IorD     = 1'b0;
      bus.MemRead  = 1'b1;
      bus.MemWrite = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegDst   = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.RegWrite = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.Branch   = 1'b0;
      bus.ALUSrcB  = 2'b01;
      bus.ALUOp    = 2'b00;
      bus.PCSource = 2'b00;
    end
  end

  assign bus.State      = state_q;
  assign bus.IllegalOp  = illegal_q;
  assign bus.InstrCount = instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, memory stalls,
// illegal opcode, reset mid-instruction and counter wrap.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rst, input logic [5:0] op, input logic mr);
    reset        = rst;
    bus.Op       = op;
    bus.MemReady = mr;
    #1;
  endtask

  initial begin
    drive(1'b1, 6'b000000, 1'b0);
    tick(); tick();
    drive(1'b1, 6'b000000, 1'b1);
    chk("rst_state", 16'(bus.State), 16'd0);
    chk("rst_count", bus.InstrCount, 16'd0);
    chk("rst_illegal", 16'(bus.IllegalOp), 16'd0);
    chk("rst_memread", 16'(bus.MemRead), 16'd1);
    chk("rst_alusrcb", 16'(bus.ALUSrcB), 16'd1);
    chk("rst_pcwrite", 16'(bus.PCWrite), 16'd0);
    chk("rst_irwrite", 16'(bus.IRWrite), 16'd0);

    // LW
    drive(1'b0, 6'b100011, 1'b1);
    chk("lw_fetch_irw", 16'(bus.IRWrite), 16'd1);
    chk("lw_fetch_pcw", 16'(bus.PCWrite), 16'd1);
    tick();
    chk("lw_s1", 16'(bus.State), 16'd1);
    chk("lw_dec_srcb", 16'(bus.ALUSrcB), 16'd3);
    tick();
    chk("lw_s2", 16'(bus.State), 16'd2);
    chk("lw_adr_srcb", 16'(bus.ALUSrcB), 16'd2);
    chk("lw_adr_srca", 16'(bus.ALUSrcA), 16'd1);
    tick();
    chk("lw_s3", 16'(bus.State), 16'd3);
    chk("lw_rd_iord", 16'(bus.IorD), 16'd1);
    chk("lw_rd_regw", 16'(bus.RegWrite), 16'd0);
    tick();
    chk("lw_s4", 16'(bus.State), 16'd4);
    chk("lw_wb_regw", 16'(bus.RegWrite), 16'd1);
    chk("lw_wb_m2r", 16'(bus.MemtoReg), 16'd1);
    tick();
    chk("lw_s0", 16'(bus.State), 16'd0);
    chk("lw_count", bus.InstrCount, 16'd1);

    // SW with stalled memory
    drive(1'b0, 6'b101011, 1'b1);
    tick(); tick(); tick();
    drive(1'b0, 6'b101011, 1'b0);
    chk("sw_s5", 16'(bus.State), 16'd5);
    chk("sw_memw", 16'(bus.MemWrite), 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_hold", 16'(bus.State), 16'd5);
    end
    chk("sw_hold_count", bus.InstrCount, 16'd1);
    drive(1'b0, 6'b101011, 1'b1);
    tick();
    chk("sw_exit", 16'(bus.State), 16'd0);
    chk("sw_count", bus.InstrCount, 16'd2);

    // R-type
    drive(1'b0, 6'b000000, 1'b1);
    tick(); tick();
    chk("r_s6", 16'(bus.State), 16'd6);
    chk("r_aluop", 16'(bus.ALUOp), 16'd2);
    tick();
    chk("r_s7", 16'(bus.State), 16'd7);
    chk("r_regdst", 16'(bus.RegDst), 16'd1);
    chk("r_regw", 16'(bus.RegWrite), 16'd1);
    tick();
    chk("r_count", bus.InstrCount, 16'd3);

    // BEQ
    drive(1'b0, 6'b000100, 1'b1);
    tick(); tick();
    chk("beq_s8", 16'(bus.State), 16'd8);
    chk("beq_aluop", 16'(bus.ALUOp), 16'd1);
    chk("beq_branch", 16'(bus.Branch), 16'd1);
    chk("beq_pcsrc", 16'(bus.PCSource), 16'd1);
    tick();
    chk("beq_s0", 16'(bus.State), 16'd0);
    chk("beq_count", bus.InstrCount, 16'd4);

    // ADDI
    drive(1'b0, 6'b001000, 1'b1);
    tick(); tick();
    chk("addi_s9", 16'(bus.State), 16'd9);
    tick();
    chk("addi_s10", 16'(bus.State), 16'd10);
    chk("addi_regw", 16'(bus.RegWrite), 16'd1);
    tick();
    chk("addi_count", bus.InstrCount, 16'd5);

    // Illegal opcode
    drive(1'b0, 6'b111111, 1'b1);
    tick();
    chk("ill_illegal_pre", 16'(bus.IllegalOp), 16'd0);
    tick();
    chk("ill_s0", 16'(bus.State), 16'd0);
    chk("ill_flag", 16'(bus.IllegalOp), 16'd1);
    chk("ill_count", bus.InstrCount, 16'd5);

    // J after illegal: flag sticky
    drive(1'b0, 6'b000010, 1'b1);
    tick(); tick();
    chk("j_s11", 16'(bus.State), 16'd11);
    chk("j_pcsrc", 16'(bus.PCSource), 16'd2);
    chk("j_pcw", 16'(bus.PCWrite), 16'd1);
    tick();
    chk("j_count", bus.InstrCount, 16'd6);
    chk("ill_sticky", 16'(bus.IllegalOp), 16'd1);

    // Fetch stall
    drive(1'b0, 6'b000010, 1'b0);
    chk("fstall_irw", 16'(bus.IRWrite), 16'd0);
    tick();
    chk("fstall_s0", 16'(bus.State), 16'd0);

    // Reset in MEMRD
    drive(1'b0, 6'b100011, 1'b1);
    tick(); tick(); tick();
    chk("rmr_s3", 16'(bus.State), 16'd3);
    drive(1'b1, 6'b100011, 1'b1);
    chk("rmr_regw_during", 16'(bus.RegWrite), 16'd0);
    tick();
    chk("rmr_s0", 16'(bus.State), 16'd0);
    chk("rmr_count", bus.InstrCount, 16'd0);
    chk("rmr_illegal", 16'(bus.IllegalOp), 16'd0);
    chk("rmr_regw", 16'(bus.RegWrite), 16'd0);

    // Counter wrap: preload near the top instead of running 65535 jumps
    drive(1'b0, 6'b000010, 1'b1);
    dut.instr_count = 16'hFFFE;
    #1;
    tick(); tick(); tick();
    chk("wrap_ffff", bus.InstrCount, 16'hFFFF);
    tick(); tick(); tick();
    chk("wrap_0000", bus.InstrCount, 16'h0000);
    chk("wrap_s0", 16'(bus.State), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
